risc_trace_monitor: RTL and testbench

- Synthesizable run-control and writeback trace monitor for the RISC core.
- Replaces the bench's open-ended print loop and `@(posedge halt)` wait with counted, buffered, watchdog-guarded observation.
- Sits beside the core and taps its writeback stage. Counts cycles and retired instructions, buffers register-write records in a FIFO drained through a valid/ready port, and ends the run on halt or timeout.

---
 rtl/risc_trace_monitor.sv | 193 +++++++++++++++++++
 tb/tb_risc_trace_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_trace_monitor.sv
// Run-control and writeback trace monitor: counts RUN cycles and retirements, buffers register writes in a FIFO.
// Optional build macro RISC_TRACE_TIMESTAMP_EN prepends cycle_count[15:0] at capture to each trace record.
`timescale 1ns/1ps

module risc_trace_monitor #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
`ifdef RISC_TRACE_TIMESTAMP_EN
  localparam int unsigned TW = REG_ADDR_WIDTH + DATA_WIDTH + 16
`else
  localparam int unsigned TW = REG_ADDR_WIDTH + DATA_WIDTH
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      halt,
  input  logic                      wb_valid,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [TW-1:0]             trace_data,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [CNT_WIDTH-1:0]      retired_count,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      timeout,
  output logic                      overflow
);

  localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_done;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_overflow;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [OCC_W-1:0]     r_count;
  logic                 r_valid;
  logic [TW-1:0]        r_trace_data;
  logic [TW-1:0]        r_mem [TRACE_DEPTH];

  logic             w_run;
  logic             w_start;
  logic             w_capture;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_tmo_hit;
  logic [TW-1:0]    w_rec;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [OCC_W-1:0] w_cnt_nxt;
  logic [TW-1:0]    w_head_nxt;

  assign w_run     = (r_state == S_RUN);
  assign w_start   = start && !w_run;
  assign w_capture = w_run && wb_valid && wb_we && (wb_rd != '0);
  assign w_full    = (r_count == OCC_W'(TRACE_DEPTH));
  assign w_pop     = r_valid && trace_ready;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;
  assign w_tmo_hit = (r_cycle == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

`ifdef RISC_TRACE_TIMESTAMP_EN
  assign w_rec = {r_cycle[15:0], wb_rd, wb_data};
`else
  assign w_rec = {wb_rd, wb_data};
`endif

  assign w_rd_nxt  = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
  assign w_wr_nxt  = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
  assign w_cnt_nxt = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

  // Next head: a record written into the slot about to become the head bypasses the array.
  always_comb begin
    w_head_nxt = '0;
    if (w_cnt_nxt != '0) begin
      if (w_push && (r_wr_ptr == w_rd_nxt)) begin
        w_head_nxt = w_rec;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  // Run-control FSM with registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (halt) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_tmo_hit) begin
            r_state   <= S_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_state   <= S_RUN;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
      endcase
    end
  end

  // Saturating counters and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle    <= '0;
      r_retired  <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_cycle    <= '0;
      r_retired  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_run && (r_cycle != '1)) begin
        r_cycle <= r_cycle + CNT_WIDTH'(1);
      end
      if (w_run && wb_valid && (r_retired != '1)) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and registered head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_trace_data <= '0;
    end else if (w_start) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_trace_data <= '0;
    end else begin
      r_rd_ptr     <= w_rd_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_count      <= w_cnt_nxt;
      r_valid      <= (w_cnt_nxt != '0);
      r_trace_data <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  assign trace_valid   = r_valid;
  assign trace_data    = r_trace_data;
  assign cycle_count   = r_cycle;
  assign retired_count = r_retired;
  assign state         = r_state;
  assign done          = r_done;
  assign timeout       = r_timeout;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_risc_trace_monitor.sv
// Scoreboard bench for risc_trace_monitor: directed writeback stimulus, queue of expected trace records.
`timescale 1ns/1ps

module tb_risc_trace_monitor;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 32;
  localparam int unsigned TO    = 24;
  localparam int unsigned RW    = AW + DW;
`ifdef RISC_TRACE_TIMESTAMP_EN
  localparam int unsigned TW = RW + 16;
`else
  localparam int unsigned TW = RW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [TW-1:0] trace_data;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] retired_count;
  logic [1:0]    state;
  logic          done;
  logic          timeout;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  risc_trace_monitor #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .TRACE_DEPTH(DEPTH),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .cycle_count(cycle_count), .retired_count(retired_count), .state(state),
    .done(done), .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    return {rd, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic v, input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_valid = v;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    trace_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    tick();
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_empty"}, 64'(trace_valid), 64'd0);
    trace_ready = 1'b0;
  endtask

  // Monitor: every accepted head must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got 0x%0h expected none", trace_data);
      end else begin
        check("sb_record", 64'(trace_data[RW-1:0]), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Test 1: asynchronous reset mid-run, then 5 non-writing retirements and halt
    do_start();
    wb(1'b1, 1'b1, 5'd7, 32'd1);
    tick();
    check("t1_pre_rst_valid", 64'(trace_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_state", 64'(state), 64'd0);
    check("t1_rst_outs", 64'({trace_valid, overflow, done, timeout}), 64'd0);
    check("t1_rst_cnts", 64'(cycle_count | retired_count), 64'd0);
    check("t1_rst_data", 64'(trace_data), 64'd0);
    wb(1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    do_start();
    wb(1'b1, 1'b0, 5'd9, 32'hDEAD);
    repeat (5) tick();
    wb(1'b0, 1'b0, '0, '0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t1_state", 64'(state), 64'd2);
    check("t1_done", 64'(done), 64'd1);
    check("t1_retired", 64'(retired_count), 64'd5);
    check("t1_cycles", 64'(cycle_count), 64'd6);
    check("t1_valid", 64'(trace_valid), 64'd0);

    // Test 2: R3=7, R0=9, R4=12 back to back, consumer always ready
    do_start();
    trace_ready = 1'b1;
    wb(1'b1, 1'b1, 5'd3, 32'd7);
    exp_q.push_back(rec(5'd3, 32'd7));
    tick();
    check("t2_r3_latency", 64'({trace_valid, trace_data[RW-1:0]}), 64'({1'b1, rec(5'd3, 32'd7)}));
    wb(1'b1, 1'b1, 5'd0, 32'd9);
    tick();
    check("t2_r0_untraced", 64'(trace_valid), 64'd0);
    wb(1'b1, 1'b1, 5'd4, 32'd12);
    exp_q.push_back(rec(5'd4, 32'd12));
    tick();
    check("t2_r4_latency", 64'({trace_valid, trace_data[RW-1:0]}), 64'({1'b1, rec(5'd4, 32'd12)}));
    wb(1'b0, 1'b0, '0, '0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    check("t2_left", 64'(exp_q.size()), 64'd0);
    check("t2_retired", 64'(retired_count), 64'd3);

    // Test 3: 17 writes into a 16-deep FIFO with no consumer, then push+pop while full
    do_start();
    trace_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      wb(1'b1, 1'b1, AW'(i), 32'h100 + 32'(i));
      if (i <= 16) exp_q.push_back(rec(AW'(i), 32'h100 + 32'(i)));
      tick();
    end
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_head", 64'({trace_valid, trace_data[RW-1:0]}), 64'({1'b1, rec(5'd1, 32'h101)}));
    trace_ready = 1'b1;
    wb(1'b1, 1'b1, 5'd18, 32'h200);
    exp_q.push_back(rec(5'd18, 32'h200));
    tick();
    trace_ready = 1'b0;
    wb(1'b0, 1'b0, '0, '0);
    check("t3_head_after_pop", 64'(trace_data[RW-1:0]), 64'(rec(5'd2, 32'h102)));
    halt = 1'b1;
    tick();
    halt = 1'b0;
    drain("t3_drain");
    check("t3_overflow_sticky", 64'(overflow), 64'd1);

    // Test 4: timeout after TO RUN cycles with an overflow pending, then restart clears it
    do_start();
    check("t4_start_clr_ovf", 64'(overflow), 64'd0);
    for (int i = 1; i <= 17; i++) begin
      wb(1'b1, 1'b1, AW'(i), 32'(i));
      if (i <= 16) exp_q.push_back(rec(AW'(i), 32'(i)));
      tick();
    end
    wb(1'b0, 1'b0, '0, '0);
    repeat (TO - 18) tick();
    check("t4_still_run", 64'(state), 64'd1);
    tick();
    check("t4_state", 64'(state), 64'd3);
    check("t4_flags", 64'({timeout, done, overflow}), 64'({1'b1, 1'b0, 1'b1}));
    check("t4_cycles", 64'(cycle_count), 64'(TO));
    check("t4_retired", 64'(retired_count), 64'd17);
    do_start();
    exp_q.delete();
    check("t4_restart_state", 64'(state), 64'd1);
    check("t4_restart_cnts", 64'({cycle_count, retired_count}), 64'd0);
    check("t4_restart_flags", 64'({overflow, trace_valid, timeout}), 64'd0);

    // Test 5: halt coincides with the timeout condition; R5=1 in that cycle is traced
    repeat (TO - 1) tick();
    halt = 1'b1;
    wb(1'b1, 1'b1, 5'd5, 32'd1);
    exp_q.push_back(rec(5'd5, 32'd1));
    tick();
    halt = 1'b0;
    wb(1'b0, 1'b0, '0, '0);
    check("t5_state", 64'(state), 64'd2);
    check("t5_flags", 64'({done, timeout}), 64'({1'b1, 1'b0}));
    check("t5_cycles", 64'(cycle_count), 64'(TO));
    check("t5_head", 64'({trace_valid, trace_data[RW-1:0]}), 64'({1'b1, rec(5'd5, 32'd1)}));
    drain("t5_drain");

`ifdef RISC_TRACE_TIMESTAMP_EN
    // Test 6: timestamped write R2=0xFFFFFFFF at RUN cycle 3
    do_start();
    repeat (3) tick();
    halt = 1'b1;
    wb(1'b1, 1'b1, 5'd2, 32'hFFFF_FFFF);
    exp_q.push_back(rec(5'd2, 32'hFFFF_FFFF));
    tick();
    halt = 1'b0;
    wb(1'b0, 1'b0, '0, '0);
    check("t6_timestamp", 64'(trace_data), 64'({16'd3, 5'd2, 32'hFFFF_FFFF}));
    drain("t6_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
